// File: rtl/speccfa_repeat_compressor.sv
// SpecCFA detect/repeat stage: fixed-priority pick of one block detection, run-length
// compression of back-to-back repeats into counter entries, and a valid/ready output queue.
module speccfa_repeat_compressor #(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned CTR_W      = 32,
    parameter int unsigned MIN_REPEAT = 2,
    parameter int unsigned ADDR_STEP  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BLOCKS-1:0]      detect_vec,
    input  logic [16*NUM_BLOCKS-1:0]   det_addr_flat,
    input  logic                       spec_ready,
    output logic                       spec_valid,
    output logic [15:0]                spec_upper,
    output logic [15:0]                spec_lower,
    output logic [15:0]                spec_addr,
    output logic                       spec_is_ctr,
    output logic                       repeat_active,
    output logic [7:0]                 active_id,
    output logic                       overflow,
    output logic                       multi_hit
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [15:0] upper;
        logic [15:0] lower;
        logic [15:0] addr;
        logic        is_ctr;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANCHORED = 2'd1,
        ST_REPEAT   = 2'd2
    } state_t;

    localparam entry_t ENTRY_ZERO = {16'h0000, 16'h0000, 16'h0000, 1'b0};

    state_t              state_q, state_d;
    logic [7:0]          anchor_id_q, anchor_id_d;
    logic [15:0]         anchor_addr_q, anchor_addr_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    entry_t              fifo_q [FIFO_DEPTH];
    entry_t              fifo_d [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    entry_t              head_q, head_d;
    logic                valid_q, valid_d;
    logic                repeat_q, repeat_d;
    logic                overflow_q, overflow_d;
    logic                multi_q, multi_d;

    logic [7:0]          det_id_s;
    logic [15:0]         det_addr_s;
    logic                det_any_s;
    logic                det_multi_s;
    logic [15:0]         step_addr_s;
    logic                match_s;
    logic                ctr_sat_s;
    logic                take_anchor_s;
    logic                take_ctr_s;
    logic                push_s;
    logic [31:0]         ctr32_s;
    entry_t              push_ent_s;
    logic                pop_s;
    logic [PW-1:0]       tail_idx_s;
    logic                coalesce_s;
    logic                write_s;
    logic                drop_s;

    // Lowest-index detection wins; scanning downward leaves the lowest set channel last.
    always_comb begin
        det_id_s   = 8'h00;
        det_addr_s = 16'h0000;
        for (int i = int'(NUM_BLOCKS) - 1; i >= 0; i--) begin
            det_id_s   = detect_vec[i] ? 8'(i + 1) : det_id_s;
            det_addr_s = detect_vec[i] ? det_addr_flat[16*i +: 16] : det_addr_s;
        end
        det_any_s   = |detect_vec;
        det_multi_s = |(detect_vec & (detect_vec - NUM_BLOCKS'(1'b1)));
    end

    // Anchor/repeat state machine and the entry it emits this cycle.
    always_comb begin
        state_d       = state_q;
        take_anchor_s = 1'b0;
        take_ctr_s    = 1'b0;
        step_addr_s   = anchor_addr_q + 16'(ADDR_STEP);
        match_s       = (det_id_s == anchor_id_q) && (det_addr_s == step_addr_s);
        ctr_sat_s     = (ctr_q == {CTR_W{1'b1}});
        case (state_q)
            ST_IDLE: begin
                take_anchor_s = det_any_s;
                state_d       = det_any_s ? ST_ANCHORED : ST_IDLE;
            end
            ST_ANCHORED: begin
                take_ctr_s    = det_any_s & match_s;
                take_anchor_s = det_any_s & ~match_s;
                state_d       = take_ctr_s ? ST_REPEAT : ST_ANCHORED;
            end
            ST_REPEAT: begin
                // A saturated counter closes the run and the detection becomes a fresh anchor.
                take_ctr_s    = det_any_s & match_s & ~ctr_sat_s;
                take_anchor_s = det_any_s & ~take_ctr_s;
                state_d       = take_anchor_s ? ST_ANCHORED : ST_REPEAT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        anchor_id_d   = take_anchor_s ? det_id_s : anchor_id_q;
        anchor_addr_d = take_anchor_s ? det_addr_s : anchor_addr_q;
        ctr_d         = take_anchor_s ? CTR_W'(1'b1)
                      : take_ctr_s    ? ((state_q == ST_REPEAT) ? ctr_q + CTR_W'(1'b1)
                                                                : CTR_W'(MIN_REPEAT))
                      : ctr_q;
        push_s        = take_anchor_s | take_ctr_s;
        ctr32_s       = 32'(ctr_d);
        push_ent_s    = take_ctr_s ? entry_t'({ctr32_s[31:16], ctr32_s[15:0], step_addr_s, 1'b1})
                                   : entry_t'({16'h1111, 8'h00, det_id_s, det_addr_s, 1'b0});
        repeat_d      = (state_d == ST_REPEAT);
    end

    // Output queue: coalesce repeated counter entries into the tail, else append or drop.
    always_comb begin
        fifo_d     = fifo_q;
        pop_s      = (count_q != CW'(1'b0)) & spec_ready;
        tail_idx_s = wr_ptr_q - PW'(1'b1);
        coalesce_s = push_s & push_ent_s.is_ctr & (count_q != CW'(1'b0))
                   & fifo_q[tail_idx_s].is_ctr & (fifo_q[tail_idx_s].addr == push_ent_s.addr)
                   & ~(pop_s & (count_q == CW'(1'b1)));
        write_s    = push_s & ~coalesce_s & ((count_q != CW'(FIFO_DEPTH)) | pop_s);
        drop_s     = push_s & ~coalesce_s & (count_q == CW'(FIFO_DEPTH)) & ~pop_s;
        fifo_d[tail_idx_s] = coalesce_s ? push_ent_s : fifo_d[tail_idx_s];
        fifo_d[wr_ptr_q]   = write_s ? push_ent_s : fifo_d[wr_ptr_q];
        rd_ptr_d   = rd_ptr_q + PW'(pop_s);
        wr_ptr_d   = wr_ptr_q + PW'(write_s);
        count_d    = count_q + CW'(write_s) - CW'(pop_s);
        valid_d    = (count_d != CW'(1'b0));
        head_d     = valid_d ? fifo_d[rd_ptr_d] : ENTRY_ZERO;
        overflow_d = overflow_q | drop_s;
        multi_d    = multi_q | det_multi_s;
    end

    // State, queue and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            anchor_id_q   <= 8'h00;
            anchor_addr_q <= 16'h0000;
            ctr_q         <= {CTR_W{1'b0}};
            for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
                fifo_q[k] <= ENTRY_ZERO;
            end
            rd_ptr_q      <= {PW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            head_q        <= ENTRY_ZERO;
            valid_q       <= 1'b0;
            repeat_q      <= 1'b0;
            overflow_q    <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            anchor_id_q   <= anchor_id_d;
            anchor_addr_q <= anchor_addr_d;
            ctr_q         <= ctr_d;
            fifo_q        <= fifo_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            valid_q       <= valid_d;
            repeat_q      <= repeat_d;
            overflow_q    <= overflow_d;
            multi_q       <= multi_d;
        end
    end

    assign spec_valid    = valid_q;
    assign spec_upper    = head_q.upper;
    assign spec_lower    = head_q.lower;
    assign spec_addr     = head_q.addr;
    assign spec_is_ctr   = head_q.is_ctr;
    assign repeat_active = repeat_q;
    assign active_id     = anchor_id_q;
    assign overflow      = overflow_q;
    assign multi_hit     = multi_q;

endmodule

// File: tb/tb_speccfa_repeat_compressor.sv
// Bench for speccfa_repeat_compressor: vector table, directed multi-cycle sequences
// and a randomized run against a queue-based reference model.
module tb_speccfa_repeat_compressor;

    localparam int NB    = 8;
    localparam int DEPTH = 4;
    localparam int STEP  = 2;
    localparam int MINR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [7:0]         dv, dv1;
    logic [16*NB-1:0]   da, da1;
    logic               rdy, rdy1;
    logic               v0, c0, rep0, ovf0, mh0;
    logic [15:0]        u0, l0, a0;
    logic [7:0]         aid0;
    logic               v1, c1, rep1, ovf1, mh1;
    logic [15:0]        u1, l1, a1;
    logic [7:0]         aid1;

    speccfa_repeat_compressor #(.NUM_BLOCKS(NB), .CTR_W(32), .MIN_REPEAT(MINR),
                                .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .detect_vec(dv), .det_addr_flat(da), .spec_ready(rdy),
        .spec_valid(v0), .spec_upper(u0), .spec_lower(l0), .spec_addr(a0), .spec_is_ctr(c0),
        .repeat_active(rep0), .active_id(aid0), .overflow(ovf0), .multi_hit(mh0));

    speccfa_repeat_compressor #(.NUM_BLOCKS(NB), .CTR_W(2), .MIN_REPEAT(MINR),
                                .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .detect_vec(dv1), .det_addr_flat(da1), .spec_ready(rdy1),
        .spec_valid(v1), .spec_upper(u1), .spec_lower(l1), .spec_addr(a1), .spec_is_ctr(c1),
        .repeat_active(rep1), .active_id(aid1), .overflow(ovf1), .multi_hit(mh1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  dv;
        logic [15:0] ad;
        logic        rdy;
        logic        ev;
        logic [15:0] eu;
        logic [15:0] el;
        logic [15:0] ea;
        logic        ec;
        logic [7:0]  eid;
        logic        erep;
    } vec_t;

    typedef struct {
        logic [15:0] u;
        logic [15:0] l;
        logic [15:0] a;
        logic        c;
    } m_ent_t;

    m_ent_t       mq[$];
    int           m_qid;
    logic [15:0]  m_raddr;
    bit           m_rep;
    longint       m_cnt;
    bit           m_ovf;
    bit           m_mh;
    localparam longint CMAX0 = (longint'(1) << 32) - 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_head0(input string nm, input logic ev, input logic [15:0] eu,
                             input logic [15:0] el, input logic [15:0] ea, input logic ec);
        logic [49:0] g;
        logic [49:0] e;
        g = ev ? {v0, u0, l0, a0, c0} : {v0, 49'd0};
        e = ev ? {1'b1, eu, el, ea, ec} : 50'd0;
        chk(nm, 64'(g), 64'(e));
    endtask

    task automatic chk_head1(input string nm, input logic [15:0] eu, input logic [15:0] el,
                             input logic [15:0] ea, input logic ec);
        chk(nm, 64'({v1, u1, l1, a1, c1}), 64'({1'b1, eu, el, ea, ec}));
    endtask

    task automatic model_reset();
        mq.delete();
        m_qid   = 0;
        m_raddr = 16'h0000;
        m_rep   = 1'b0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_mh    = 1'b0;
    endtask

    // Reference: one clock of the compressor described by its entry-level rules.
    task automatic model_step(input logic [7:0] v, input logic [16*NB-1:0] ad, input logic r);
        bit          popping;
        bit          have;
        bit          coal;
        int          win;
        int          nb;
        m_ent_t      e;
        logic [15:0] a;
        logic [15:0] nxt;
        popping = (mq.size() != 0) && r;
        win = -1;
        nb = 0;
        have = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (v[i]) begin
                nb++;
                if (win < 0) win = i;
            end
        end
        if (nb > 1) m_mh = 1'b1;
        if (win >= 0) begin
            a   = ad[16*win +: 16];
            nxt = m_raddr + 16'(STEP);
            have = 1'b1;
            if ((win + 1) == m_qid && a == nxt && !(m_rep && m_cnt == CMAX0)) begin
                m_cnt = m_rep ? m_cnt + 1 : longint'(MINR);
                m_rep = 1'b1;
                e.u = 16'(m_cnt >> 16);
                e.l = 16'(m_cnt);
                e.a = nxt;
                e.c = 1'b1;
            end else begin
                m_qid   = win + 1;
                m_raddr = a;
                m_rep   = 1'b0;
                m_cnt   = 1;
                e.u = 16'h1111;
                e.l = 16'(win + 1);
                e.a = a;
                e.c = 1'b0;
            end
        end
        coal = have && e.c && mq.size() != 0 && mq[mq.size()-1].c && mq[mq.size()-1].a == e.a
               && !(popping && mq.size() == 1);
        if (popping) void'(mq.pop_front());
        if (have) begin
            if (coal) mq[mq.size()-1] = e;
            else if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic cmp_model(input int cyc);
        logic [49:0] g;
        logic [49:0] e;
        g = v0 ? {1'b1, u0, l0, a0, c0} : 50'd0;
        e = (mq.size() != 0) ? {1'b1, mq[0].u, mq[0].l, mq[0].a, mq[0].c} : 50'd0;
        chk($sformatf("rand_head_c%0d", cyc), 64'(g), 64'(e));
        chk($sformatf("rand_state_c%0d", cyc), 64'({aid0, rep0, ovf0, mh0}),
            64'({8'(m_qid), m_rep, m_ovf, m_mh}));
    endtask

    vec_t tbl[10];

    initial begin
        reset = 1'b1; dv = 8'h00; da = '0; rdy = 1'b1;
        dv1 = 8'h00; da1 = '0; rdy1 = 1'b1;

        tbl[0] = '{8'h04, 16'h0100, 1'b1, 1'b1, 16'h1111, 16'h0003, 16'h0100, 1'b0, 8'd3, 1'b0};
        tbl[1] = '{8'h04, 16'h0102, 1'b1, 1'b1, 16'h0000, 16'h0002, 16'h0102, 1'b1, 8'd3, 1'b1};
        tbl[2] = '{8'h04, 16'h0102, 1'b1, 1'b1, 16'h0000, 16'h0003, 16'h0102, 1'b1, 8'd3, 1'b1};
        tbl[3] = '{8'h04, 16'h0102, 1'b1, 1'b1, 16'h0000, 16'h0004, 16'h0102, 1'b1, 8'd3, 1'b1};
        tbl[4] = '{8'h04, 16'h0102, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0102, 1'b1, 8'd3, 1'b1};
        tbl[5] = '{8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd3, 1'b1};
        tbl[6] = '{8'h04, 16'h0104, 1'b1, 1'b1, 16'h1111, 16'h0003, 16'h0104, 1'b0, 8'd3, 1'b0};
        tbl[7] = '{8'h01, 16'h0106, 1'b1, 1'b1, 16'h1111, 16'h0001, 16'h0106, 1'b0, 8'd1, 1'b0};
        tbl[8] = '{8'h06, 16'h0200, 1'b1, 1'b1, 16'h1111, 16'h0002, 16'h0200, 1'b0, 8'd2, 1'b0};
        tbl[9] = '{8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd2, 1'b0};

        tick();
        chk("reset_state", 64'({v0, u0, l0, a0, c0, rep0, aid0, ovf0, mh0}), 64'd0);
        chk("reset_state_d1", 64'({v1, aid1, rep1}), 64'd0);
        reset = 1'b0;

        // Saturating 2-bit counter: run closes, restarts as anchor, then a new run.
        dv1 = 8'h01;
        da1 = {NB{16'h0010}}; tick(); chk_head1("sat_id0", 16'h1111, 16'h0001, 16'h0010, 1'b0);
        chk("sat_rep0", 64'({aid1, rep1}), 64'({8'd1, 1'b0}));
        da1 = {NB{16'h0012}}; tick(); chk_head1("sat_ctr2", 16'h0000, 16'h0002, 16'h0012, 1'b1);
        da1 = {NB{16'h0012}}; tick(); chk_head1("sat_ctr3", 16'h0000, 16'h0003, 16'h0012, 1'b1);
        chk("sat_rep2", 64'({aid1, rep1}), 64'({8'd1, 1'b1}));
        da1 = {NB{16'h0012}}; tick(); chk_head1("sat_reanchor", 16'h1111, 16'h0001, 16'h0012, 1'b0);
        chk("sat_rep3", 64'({aid1, rep1}), 64'({8'd1, 1'b0}));
        da1 = {NB{16'h0014}}; tick(); chk_head1("sat_newrun", 16'h0000, 16'h0002, 16'h0014, 1'b1);
        dv1 = 8'h00; tick();
        chk("sat_flags_d1", 64'({v1, ovf1, mh1}), 64'd0);

        for (int i = 0; i < 10; i++) begin
            dv = tbl[i].dv; da = {NB{tbl[i].ad}}; rdy = tbl[i].rdy;
            tick();
            chk_head0($sformatf("vec%0d_head", i), tbl[i].ev, tbl[i].eu, tbl[i].el, tbl[i].ea, tbl[i].ec);
            chk($sformatf("vec%0d_anchor", i), 64'({aid0, rep0}), 64'({tbl[i].eid, tbl[i].erep}));
        end
        chk("vec_sticky", 64'({mh0, ovf0}), 64'({1'b1, 1'b0}));

        // Repeats while the writer stalls collapse into one counter entry.
        reset = 1'b1; dv = 8'h00; tick(); reset = 1'b0;
        chk("rst_clears_sticky", 64'({mh0, ovf0, v0}), 64'd0);
        rdy = 1'b0; dv = 8'h04; da = {NB{16'h0100}}; tick();
        chk_head0("stall_id", 1'b1, 16'h1111, 16'h0003, 16'h0100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            da = {NB{16'h0102}}; tick();
            chk_head0($sformatf("stall_hold%0d", k), 1'b1, 16'h1111, 16'h0003, 16'h0100, 1'b0);
        end
        dv = 8'h00; rdy = 1'b1; tick();
        chk_head0("stall_ctr5", 1'b1, 16'h0000, 16'h0005, 16'h0102, 1'b1);
        tick();
        chk_head0("stall_empty", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("stall_ovf", 64'(ovf0), 64'd0);

        // Overflow on a full queue, then reset mid-run.
        rdy = 1'b0; dv = 8'h01;
        for (int k = 0; k < 4; k++) begin
            da = {NB{16'h0400 + 16'(k * 16)}}; tick();
            chk_head0($sformatf("ovf_fill%0d", k), 1'b1, 16'h1111, 16'h0001, 16'h0400, 1'b0);
        end
        chk("ovf_not_yet", 64'(ovf0), 64'd0);
        da = {NB{16'h0440}}; tick();
        chk("ovf_set", 64'(ovf0), 64'd1);
        chk_head0("ovf_head_kept", 1'b1, 16'h1111, 16'h0001, 16'h0400, 1'b0);
        reset = 1'b1; dv = 8'h00; tick(); reset = 1'b0;
        chk("midrun_reset", 64'({v0, aid0, ovf0, rep0}), 64'd0);

        // Push and pop together on a full queue loses nothing.
        rdy = 1'b0; dv = 8'h01;
        for (int k = 0; k < 4; k++) begin
            da = {NB{16'h0500 + 16'(k * 16)}}; tick();
        end
        rdy = 1'b1; da = {NB{16'h0540}}; tick();
        chk_head0("full_pushpop", 1'b1, 16'h1111, 16'h0001, 16'h0510, 1'b0);
        chk("full_pushpop_ovf", 64'(ovf0), 64'd0);
        dv = 8'h00;
        for (int k = 2; k < 5; k++) begin
            tick();
            chk_head0($sformatf("drain%0d", k), 1'b1, 16'h1111, 16'h0001, 16'h0500 + 16'(k * 16), 1'b0);
        end
        tick();
        chk_head0("drain_empty", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // Randomized traffic against the reference model.
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 9);
            dv = 8'h00;
            for (int i = 0; i < NB; i++) da[16*i +: 16] = 16'h0300 + 16'($urandom_range(0, 7) * 2);
            case (r)
                0, 1, 2, 3: if (m_qid != 0) begin
                    dv[m_qid-1] = 1'b1; da[16*(m_qid-1) +: 16] = m_raddr + 16'(STEP);
                end
                4: if (m_qid != 0) begin
                    dv[m_qid-1] = 1'b1; da[16*(m_qid-1) +: 16] = m_raddr;
                end
                5, 6: dv[$urandom_range(0, NB-1)] = 1'b1;
                7: dv = 8'($urandom_range(1, 255));
                default: dv = 8'h00;
            endcase
            rdy = ((c % 50) < 12) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            model_step(dv, da, rdy);
            tick();
            cmp_model(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
